// File: rtl/decode_if.sv
//==============================================================================
// Module   : decode_if
// Purpose  : Fetch-side and execute-side handshake/field bundle of the decode stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface decode_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm;
    logic [25:0]     addr;
    logic [31:0]     imm_ext;
    logic [PC_W-1:0] pc_out;

    // master = fetch/execute environment, slave = the decode stage
    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               imm, addr, imm_ext, pc_out
    );

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               imm, addr, imm_ext, pc_out
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
//==============================================================================
// Module   : decode_stage
// Purpose  : Buffered MIPS decode stage with load-use bubble and flush.
//            Optional macro DECODE_PERF_EN enables the bubble counter.
// Revision : 1.0
//==============================================================================
`default_nettype none

module decode_stage #(
    parameter int PC_W         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int SIGN_EXT_LUI = 0
) (
    input  wire logic        CLK,
    input  wire logic        nRST,
    input  wire logic        flush,
    decode_if.slave          bus,
    output logic             load_use_stall,
    output logic [31:0]      perf_stall_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;

    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic [PC_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_imm;
    logic            out_valid_q;
    logic            stall_q;

    logic [31:0]     head_instr;
    logic [PC_W-1:0] head_pc;
    logic            head_present;
    logic            head_reads_rs;
    logic            head_reads_rt;
    logic            out_is_load;
    logic            load_hazard;
    logic            load;
    logic            push;
    logic            pop;
    logic            in_ready_w;

    function automatic logic [31:0] extend_imm(input logic [31:0] word);
        logic [31:0] ext;
        case (word[31:26])
            OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0000, word[15:0]};
            OP_LUI: ext = (SIGN_EXT_LUI != 0) ? {word[15:0], 16'h0000}
                                              : {16'h0000, word[15:0]};
            default: ext = {{16{word[15]}}, word[15:0]};
        endcase
        return ext;
    endfunction

    assign head_instr   = instr_mem[rd_ptr];
    assign head_pc      = pc_mem[rd_ptr];
    assign head_present = (count != '0);
    assign in_ready_w   = (count < DEPTH_C);

    always_comb begin
        head_reads_rs = 1'b1;
        head_reads_rt = 1'b0;
        case (head_instr[31:26])
            OP_J, OP_JAL, OP_LUI: head_reads_rs = 1'b0;
            default:              head_reads_rs = 1'b1;
        endcase
        case (head_instr[31:26])
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_SC: head_reads_rt = 1'b1;
            default:                                head_reads_rt = 1'b0;
        endcase
    end

    assign out_is_load = (out_instr[31:26] == OP_LW) || (out_instr[31:26] == OP_LL);

    // Only checked as the load leaves; the bubble cycle has no handshake, so the
    // head moves on the next cycle without being re-examined.
    assign load_hazard = !flush && out_valid_q && bus.out_ready && out_is_load
                       && (out_instr[20:16] != 5'd0) && head_present
                       && ((head_reads_rs && (head_instr[25:21] == out_instr[20:16]))
                        || (head_reads_rt && (head_instr[20:16] == out_instr[20:16])));

    assign load = !flush && (!out_valid_q || bus.out_ready) && head_present && !load_hazard;
    assign pop  = load;
    assign push = !flush && bus.in_valid && in_ready_w;

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.instr_in;
            pc_mem[wr_ptr]    <= bus.pc_in;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_imm     <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_q <= load_hazard;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (load) begin
                out_valid_q <= 1'b1;
                out_instr   <= head_instr;
                out_pc      <= head_pc;
                out_imm     <= extend_imm(head_instr);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = out_instr[31:26];
    assign bus.rs        = out_instr[25:21];
    assign bus.rt        = out_instr[20:16];
    assign bus.rd        = out_instr[15:11];
    assign bus.shamt     = out_instr[10:6];
    assign bus.funct     = out_instr[5:0];
    assign bus.imm       = out_instr[15:0];
    assign bus.addr      = out_instr[25:0];
    assign bus.imm_ext   = out_imm;
    assign bus.pc_out    = out_pc;

    assign load_use_stall = stall_q && !flush;

`ifdef DECODE_PERF_EN
    logic [31:0] stall_cnt;

    // Survives flush on purpose: it counts bubbles over the whole run.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (load_use_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
